// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: rising-edge detection, per-source masks with
// a global enable, fixed priority (lowest index wins), and a three-state
// request/acknowledge/service handshake with the CPU.
module irq_ctrl #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            wr_en,
  input  logic [1:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic [31:0]     pc_in,
  output logic            irq_req,
  input  logic            irq_ack,
  input  logic            irq_done,
  output logic [IDW-1:0]  irq_id,
  output logic [31:0]     irq_vector,
  output logic [31:0]     epc,
  output logic            irq_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_VBASE   = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  state_t          state;
  state_t          state_next;
  logic [NSRC-1:0] src_prev;
  logic            armed;
  logic [31:0]     enable;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_next;
  logic [31:0]     vbase;
  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] enable_mask;
  logic [NSRC-1:0] masked;
  logic            gie;
  logic [IDW-1:0]  win_id;
  logic            take;
  logic            ack_take;
  logic [31:0]     status;

  assign gie         = enable[31];
  assign enable_mask = enable[NSRC-1:0];
  assign masked      = pending & enable_mask;

  // Edges are suppressed for the first cycle after reset release so a line
  // already high at release is not mistaken for a new event.
  assign src_edge = armed ? (irq_src & ~src_prev) : '0;

  // Fixed-priority pick: scanning downward lets the lowest set index win.
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        win_id = IDW'(i);
      end
    end
  end

  // Next-state logic for the request/service handshake.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (gie && (|masked)) begin
          take       = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack_take   = 1'b1;
          state_next = SERVICE;
        end else if (!pending[irq_id] || !enable_mask[irq_id] || !gie) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending update: software clears and acknowledge clear first, then new
  // edges are OR-ed in so a same-cycle edge is never lost.
  always_comb begin
    pending_next = pending;
    if (wr_en && (addr == A_PENDING)) begin
      pending_next = pending_next & ~wr_data[NSRC-1:0];
    end
    if (ack_take) begin
      pending_next[irq_id] = 1'b0;
    end
    pending_next = pending_next | src_edge;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Edge history, software registers, latched ID and return pc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_prev <= '0;
      armed    <= 1'b0;
      enable   <= '0;
      pending  <= '0;
      vbase    <= '0;
      irq_id   <= '0;
      epc      <= '0;
    end else begin
      src_prev <= irq_src;
      armed    <= 1'b1;
      pending  <= pending_next;
      if (wr_en && (addr == A_ENABLE)) begin
        enable <= wr_data;
      end
      if (wr_en && (addr == A_VBASE)) begin
        vbase <= wr_data;
      end
      if (take) begin
        irq_id <= win_id;
      end
      if (ack_take) begin
        epc <= pc_in;
      end
    end
  end

  assign irq_req    = (state == REQ);
  assign irq_active = (state == SERVICE);
  assign irq_vector = vbase + {{(30 - IDW){1'b0}}, irq_id, 2'b00};

  // Register read mux; STATUS packs the FSM state and current ID.
  always_comb begin
    status             = '0;
    status[9:8]        = state;
    status[IDW-1:0]    = irq_id;
    rd_data            = '0;
    case (addr)
      A_ENABLE:  rd_data = enable;
      A_PENDING: rd_data[NSRC-1:0] = pending;
      A_VBASE:   rd_data = vbase;
      A_STATUS:  rd_data = status;
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [31:0] pc_in;
  logic        irq_req;
  logic        irq_ack;
  logic        irq_done;
  logic [1:0]  irq_id;
  logic [31:0] irq_vector;
  logic [31:0] epc;
  logic        irq_active;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] d;

  irq_ctrl #(.NSRC(4), .IDW(2)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .wr_en(wr_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .pc_in(pc_in),
    .irq_req(irq_req), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_id(irq_id), .irq_vector(irq_vector), .epc(epc),
    .irq_active(irq_active)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
    wr_en = 1'b1; addr = a; wr_data = v;
    tick();
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic pulse(input logic [3:0] s);
    irq_src = s;
    tick();
    irq_src = '0;
  endtask

  task automatic ack(input logic [31:0] pc);
    pc_in = pc; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req got %b want 0", irq_req); end
    n_cmp++; if (irq_active !== 1'b0) begin n_err++; $display("[TB] FAIL reset_active got %b want 0", irq_active); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_id got %0d want 0", irq_id); end
    n_cmp++; if (epc !== 32'h0) begin n_err++; $display("[TB] FAIL reset_epc got %h want 0", epc); end
    rd_reg(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("[TB] FAIL reset_enable got %h want 0", d); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    wr_reg(2'd0, 32'h8000_0001);
    wr_reg(2'd2, 32'h0000_0100);
    pulse(4'b0001);
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL basic_req_early got %b want 0", irq_req); end
    tick();
    n_cmp++; if (irq_req !== 1'b1) begin n_err++; $display("[TB] FAIL basic_req got %b want 1", irq_req); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("[TB] FAIL basic_id got %0d want 0", irq_id); end
    n_cmp++; if (irq_vector !== 32'h100) begin n_err++; $display("[TB] FAIL basic_vector got %h want 00000100", irq_vector); end
    tick();
    n_cmp++; if (irq_req !== 1'b1) begin n_err++; $display("[TB] FAIL basic_req_hold got %b want 1", irq_req); end
  endtask

  task automatic test_ack_done();
    ack(32'h44);
    n_cmp++; if (epc !== 32'h44) begin n_err++; $display("[TB] FAIL ack_epc got %h want 00000044", epc); end
    n_cmp++; if (irq_active !== 1'b1) begin n_err++; $display("[TB] FAIL ack_active got %b want 1", irq_active); end
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL ack_req got %b want 0", irq_req); end
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("[TB] FAIL ack_pending got %h want 0", d); end
    rd_reg(2'd3, d);
    n_cmp++; if (d[9:8] !== 2'd2) begin n_err++; $display("[TB] FAIL ack_status got %0d want 2", d[9:8]); end
    done();
    n_cmp++; if (irq_active !== 1'b0) begin n_err++; $display("[TB] FAIL done_active got %b want 0", irq_active); end
    rd_reg(2'd3, d);
    n_cmp++; if (d[9:8] !== 2'd0) begin n_err++; $display("[TB] FAIL done_status got %0d want 0", d[9:8]); end
  endtask

  task automatic test_priority();
    wr_reg(2'd0, 32'h8000_000F);
    pulse(4'b1010);
    tick();
    n_cmp++; if (irq_id !== 2'd1) begin n_err++; $display("[TB] FAIL prio_id1 got %0d want 1", irq_id); end
    n_cmp++; if (irq_vector !== 32'h104) begin n_err++; $display("[TB] FAIL prio_vec1 got %h want 00000104", irq_vector); end
    ack(32'h10);
    done();
    tick();
    n_cmp++; if (irq_req !== 1'b1) begin n_err++; $display("[TB] FAIL prio_req3 got %b want 1", irq_req); end
    n_cmp++; if (irq_id !== 2'd3) begin n_err++; $display("[TB] FAIL prio_id3 got %0d want 3", irq_id); end
    n_cmp++; if (irq_vector !== 32'h10C) begin n_err++; $display("[TB] FAIL prio_vec3 got %h want 0000010c", irq_vector); end
    pulse(4'b0001);
    tick();
    n_cmp++; if (irq_id !== 2'd3) begin n_err++; $display("[TB] FAIL prio_stable got %0d want 3", irq_id); end
    ack(32'h20);
    done();
    tick();
    n_cmp++; if (irq_id !== 2'd0 || irq_req !== 1'b1) begin n_err++; $display("[TB] FAIL prio_id0 got id=%0d req=%b want id=0 req=1", irq_id, irq_req); end
    ack(32'h30);
    done();
  endtask

  task automatic test_service_block();
    pulse(4'b0010);
    tick();
    n_cmp++; if (irq_id !== 2'd1) begin n_err++; $display("[TB] FAIL svc_id1 got %0d want 1", irq_id); end
    ack(32'h40);
    pulse(4'b0100);
    tick();
    n_cmp++; if (irq_req !== 1'b0 || irq_active !== 1'b1) begin n_err++; $display("[TB] FAIL svc_nonest got req=%b act=%b want req=0 act=1", irq_req, irq_active); end
    done();
    tick();
    n_cmp++; if (irq_req !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("[TB] FAIL svc_after got req=%b id=%0d want req=1 id=2", irq_req, irq_id); end
    ack(32'h50);
    done();
  endtask

  task automatic test_pending_clear();
    pulse(4'b0001);
    tick();
    n_cmp++; if (irq_req !== 1'b1) begin n_err++; $display("[TB] FAIL clr_req got %b want 1", irq_req); end
    wr_reg(2'd1, 32'h1);
    tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL clr_withdraw got %b want 0", irq_req); end
    rd_reg(2'd3, d);
    n_cmp++; if (d[9:8] !== 2'd0) begin n_err++; $display("[TB] FAIL clr_state got %0d want 0", d[9:8]); end
    pulse(4'b0001);
    tick();
    irq_src = 4'b0001;
    wr_en = 1'b1; addr = 2'd1; wr_data = 32'h1;
    tick();
    wr_en = 1'b0; wr_data = '0; irq_src = '0;
    repeat (2) tick();
    n_cmp++; if (irq_req !== 1'b1 || irq_id !== 2'd0) begin n_err++; $display("[TB] FAIL clr_setwins got req=%b id=%0d want req=1 id=0", irq_req, irq_id); end
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("[TB] FAIL clr_pending got %h want 00000001", d); end
    ack(32'h60);
    done();
  endtask

  task automatic test_wrap_withdraw();
    wr_reg(2'd2, 32'hFFFF_FFFC);
    pulse(4'b0010);
    tick();
    n_cmp++; if (irq_vector !== 32'h0) begin n_err++; $display("[TB] FAIL wrap_vec got %h want 00000000", irq_vector); end
    wr_reg(2'd0, 32'h0000_000F);
    tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL gie_withdraw got %b want 0", irq_req); end
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("[TB] FAIL gie_pending got %h want 00000002", d); end
    wr_reg(2'd3, 32'hFFFF_FFFF);
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("[TB] FAIL status_ro got %h want 00000001", d); end
    wr_reg(2'd1, 32'h2);
    wr_reg(2'd2, 32'h100);
    wr_reg(2'd0, 32'h8000_000F);
    tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_idle got %b want 0", irq_req); end
  endtask

  task automatic test_reset_abort();
    pulse(4'b0010);
    tick();
    ack(32'h88);
    pulse(4'b0110);
    tick();
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h6) begin n_err++; $display("[TB] FAIL abort_pre_pending got %h want 00000006", d); end
    n_cmp++; if (irq_active !== 1'b1 || epc !== 32'h88) begin n_err++; $display("[TB] FAIL abort_pre got act=%b epc=%h want act=1 epc=00000088", irq_active, epc); end
    irq_src = 4'b1000;
    reset = 1'b0;
    #1;
    n_cmp++; if (irq_req !== 1'b0 || irq_active !== 1'b0) begin n_err++; $display("[TB] FAIL abort_flags got req=%b act=%b want 0 0", irq_req, irq_active); end
    n_cmp++; if (epc !== 32'h0 || irq_id !== 2'd0 || irq_vector !== 32'h0) begin n_err++; $display("[TB] FAIL abort_regs got epc=%h id=%0d vec=%h want 0", epc, irq_id, irq_vector); end
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("[TB] FAIL abort_pending got %h want 0", d); end
    tick();
    reset = 1'b1;
    repeat (3) tick();
    wr_reg(2'd0, 32'h8000_000F);
    repeat (2) tick();
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("[TB] FAIL held_pending got %h want 0", d); end
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("[TB] FAIL held_req got %b want 0", irq_req); end
    irq_src = '0;
  endtask

  // Scenario sequence.
  initial begin
    reset = 1'b0; irq_src = '0; wr_en = 1'b0; addr = '0; wr_data = '0;
    pc_in = '0; irq_ack = 1'b0; irq_done = 1'b0;
    test_reset();
    test_basic();
    test_ack_done();
    test_priority();
    test_service_block();
    test_pending_clear();
    test_wrap_withdraw();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
